// File: rtl/apb_slave_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : apb_slave_mem
// Brief    : APB completer serving a byte-strobed word memory with a fixed
//            number of wait states and an error response for out-of-range.
// Revision : 1.0 - initial release
// ============================================================================
module apb_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int STRB_SIZE   = 4,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sel_i,
    input  logic                  enable_i,
    input  logic                  write_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [STRB_SIZE-1:0]  strobe_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  ready_o,
    output logic                  slverr_o
);

    localparam int LSB   = $clog2(STRB_SIZE);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   write_q, write_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   oor_q, oor_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0]  w_word;
    logic                   w_oor;
    logic                   w_setup;
    logic                   w_access;
    logic                   w_load;
    logic                   w_commit;
    logic                   w_ready;

    assign w_word   = addr_i >> LSB;
    assign w_oor    = (w_word >= ADDR_WIDTH'(DEPTH));
    assign w_setup  = sel_i && !enable_i;
    assign w_access = sel_i && enable_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            oor_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            oor_q   <= oor_d;
            rdata_q <= rdata_d;
        end
    end

    // With WAIT_CYCLES=0 the first WAIT cycle is itself the response cycle;
    // otherwise WAIT hands over to RESP one cycle before the count would expire.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        idx_d    = idx_q;
        oor_d    = oor_q;
        rdata_d  = rdata_q;
        w_load   = 1'b0;
        w_commit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_setup) w_load = 1'b1;
            end
            S_WAIT: begin
                if (!w_access) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    w_commit = write_q && !oor_q;
                    state_d  = S_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (!sel_i) begin
                    state_d = S_IDLE;
                end else if (enable_i) begin
                    w_commit = write_q && !oor_q;
                    state_d  = S_IDLE;
                end else begin
                    w_load = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (w_load) begin
            state_d = S_WAIT;
            write_d = write_i;
            idx_d   = w_word[IDX_W-1:0];
            oor_d   = w_oor;
            cnt_d   = CNT_W'(WAIT_CYCLES);
            rdata_d = (write_i || w_oor) ? '0 : mem_q[w_word[IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (w_commit) begin
            for (int b = 0; b < STRB_SIZE; b++) begin
                if (strobe_i[b]) mem_q[idx_q][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign w_ready  = ((state_q == S_WAIT) && (cnt_q == '0)) || (state_q == S_RESP);
    assign ready_o  = w_ready;
    assign slverr_o = w_ready && oor_q;
    assign rdata_o  = (w_ready && !write_q) ? rdata_q : '0;

endmodule
`default_nettype wire
